parity_gen_chk: RTL and testbench

Parametrised parity unit for the UART datapath. It computes the parity bit of a parallel word on the transmit side, and checks the parity of a bit-serial frame on the receive side. The checker reports a per-frame result and a saturating error count. It replaces the fixed 8-bit even/odd generator. It sits between the TX serializer (parallel generate path) and the RX sampler (serial check path).

---
 rtl/parity_pkg.sv | 28 ++
 rtl/parity_gen_chk_if.sv | 31 +++
 rtl/parity_rx_chk.sv | 110 +++++++++++
 rtl/parity_gen_chk.sv | 42 ++++
 tb/tb_parity_gen_chk.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the UART parity unit: parity modes, checker FSM
// encoding and the expected-parity function used by both paths.
package parity_pkg;

    typedef logic [1:0] par_typ_t;

    localparam par_typ_t PAR_EVEN  = 2'b00;
    localparam par_typ_t PAR_ODD   = 2'b01;
    localparam par_typ_t PAR_MARK  = 2'b10;
    localparam par_typ_t PAR_SPACE = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAR  = 2'd2;

    // xor_in is the XOR reduction of the data bits
    function automatic logic exp_parity(input logic xor_in, input par_typ_t typ);
        logic p;
        case (typ)
            PAR_EVEN: p = xor_in;
            PAR_ODD:  p = ~xor_in;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/parity_gen_chk_if.sv
// Bus bundle for the parity unit: TX generate path and RX check path.
interface parity_gen_chk_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ERR_CNT_W  = 8
);
    logic [1:0]            PAR_TYP;
    logic                  PAR_EN;
    logic [DATA_WIDTH-1:0] P_Data;
    logic                  Data_Valid;
    logic                  par_bit;
    logic                  Frame_Start;
    logic                  S_Data;
    logic                  S_Strobe;
    logic                  Err_Clr;
    logic                  chk_done;
    logic                  par_err;
    logic [ERR_CNT_W-1:0]  err_cnt;

    modport master (
        output PAR_TYP, PAR_EN, P_Data, Data_Valid,
        output Frame_Start, S_Data, S_Strobe, Err_Clr,
        input  par_bit, chk_done, par_err, err_cnt
    );

    modport slave (
        input  PAR_TYP, PAR_EN, P_Data, Data_Valid,
        input  Frame_Start, S_Data, S_Strobe, Err_Clr,
        output par_bit, chk_done, par_err, err_cnt
    );

endinterface

// File: rtl/parity_rx_chk.sv
// Serial parity checker: frames LSB-first data bits plus optional parity bit,
// pulses a per-frame result and keeps a saturating error count.
module parity_rx_chk
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  par_typ_t             par_typ,
    input  logic                 par_en,
    input  logic                 frame_start,
    input  logic                 s_data,
    input  logic                 s_strobe,
    input  logic                 err_clr,
    output logic                 chk_done,
    output logic                 par_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic             acc, acc_nxt;
    par_typ_t         typ_l, typ_l_nxt;
    logic             en_l, en_l_nxt;
    logic             done_nxt;
    logic             err_nxt;

    // Frame_Start has priority over everything, including a same-cycle strobe
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        acc_nxt     = acc;
        typ_l_nxt   = typ_l;
        en_l_nxt    = en_l;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        if (frame_start) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
            acc_nxt     = 1'b0;
            typ_l_nxt   = par_typ;
            en_l_nxt    = par_en;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_DATA: begin
                    if (s_strobe) begin
                        acc_nxt     = acc ^ s_data;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            if (en_l) begin
                                state_nxt = ST_PAR;
                            end else begin
                                state_nxt = ST_IDLE;
                                done_nxt  = 1'b1;
                            end
                        end
                    end
                end
                ST_PAR: begin
                    if (s_strobe) begin
                        done_nxt  = 1'b1;
                        err_nxt   = (s_data != exp_parity(acc, typ_l));
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            acc      <= 1'b0;
            typ_l    <= PAR_EVEN;
            en_l     <= 1'b0;
            chk_done <= 1'b0;
            par_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            acc      <= acc_nxt;
            typ_l    <= typ_l_nxt;
            en_l     <= en_l_nxt;
            chk_done <= done_nxt;
            par_err  <= err_nxt;
        end
    end

    // A clear coinciding with a new error leaves that error counted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= err_nxt ? ERR_CNT_W'(1) : '0;
        end else if (err_nxt && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/parity_gen_chk.sv
// UART parity unit: registered TX parity generator plus the RX serial checker.
module parity_gen_chk
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    parity_gen_chk_if.slave  bus
);

    logic par_bit_p1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_bit_p1 <= 1'b0;
        end else if (bus.Data_Valid) begin
            par_bit_p1 <= exp_parity(^bus.P_Data, bus.PAR_TYP);
        end
    end

    assign bus.par_bit = par_bit_p1;

    parity_rx_chk #(
        .DATA_WIDTH (DATA_WIDTH),
        .ERR_CNT_W  (ERR_CNT_W)
    ) u_rx_chk (
        .CLK         (CLK),
        .RST         (RST),
        .par_typ     (bus.PAR_TYP),
        .par_en      (bus.PAR_EN),
        .frame_start (bus.Frame_Start),
        .s_data      (bus.S_Data),
        .s_strobe    (bus.S_Strobe),
        .err_clr     (bus.Err_Clr),
        .chk_done    (bus.chk_done),
        .par_err     (bus.par_err),
        .err_cnt     (bus.err_cnt)
    );

endmodule

// File: tb/tb_parity_gen_chk.sv
// Directed bench for parity_gen_chk with DATA_WIDTH=8 and a 2-bit error counter.
module tb_parity_gen_chk;
    import parity_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    parity_gen_chk_if #(.DATA_WIDTH(8), .ERR_CNT_W(2)) bus ();

    parity_gen_chk #(.DATA_WIDTH(8), .ERR_CNT_W(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] data;
        logic [1:0] typ;
        logic       exp;
    } gen_vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] typ;
        logic       en;
        logic       pbit;
        logic       exp_err;
        logic [1:0] exp_cnt;
    } frm_vec_t;

    gen_vec_t gen_tbl[7];
    frm_vec_t frm_tbl[6];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic strobe(input logic b);
        bus.S_Strobe = 1'b1;
        bus.S_Data   = b;
        tick();
        bus.S_Strobe = 1'b0;
        bus.S_Data   = 1'b0;
    endtask

    // PAR_TYP/PAR_EN are flipped after Frame_Start to prove they are latched
    task automatic run_frame(input logic [7:0] data, input logic [1:0] typ, input logic en,
                             input logic pbit, input logic clr, input logic exp_err,
                             input logic [1:0] exp_cnt);
        bus.Frame_Start = 1'b1;
        bus.PAR_TYP     = typ;
        bus.PAR_EN      = en;
        tick();
        bus.Frame_Start = 1'b0;
        check("done_single_cycle", bus.chk_done, 0);
        bus.PAR_TYP = ~typ;
        bus.PAR_EN  = ~en;
        for (int i = 0; i < 8; i++) begin
            strobe(data[i]);
            if (i == 7 && !en) begin
                check("noparity_done", bus.chk_done, 1);
                check("noparity_err", bus.par_err, 0);
                check("noparity_cnt", bus.err_cnt, exp_cnt);
            end else begin
                check("data_no_done", bus.chk_done, 0);
            end
        end
        if (en) begin
            bus.Err_Clr = clr;
            strobe(pbit);
            bus.Err_Clr = 1'b0;
            check("frame_done", bus.chk_done, 1);
            check("frame_err", bus.par_err, exp_err);
            check("frame_cnt", bus.err_cnt, exp_cnt);
        end
    endtask

    task automatic pulse_clr(input string name);
        bus.Err_Clr = 1'b1;
        tick();
        bus.Err_Clr = 1'b0;
        check(name, bus.err_cnt, 0);
    endtask

    initial begin
        gen_tbl[0] = '{8'hA5, PAR_EVEN,  1'b0};
        gen_tbl[1] = '{8'hA5, PAR_ODD,   1'b1};
        gen_tbl[2] = '{8'hA5, PAR_MARK,  1'b1};
        gen_tbl[3] = '{8'hA5, PAR_SPACE, 1'b0};
        gen_tbl[4] = '{8'hFF, PAR_ODD,   1'b1};
        gen_tbl[5] = '{8'h80, PAR_ODD,   1'b0};
        gen_tbl[6] = '{8'h07, PAR_EVEN,  1'b1};

        frm_tbl[0] = '{8'h07, PAR_EVEN,  1'b1, 1'b1, 1'b0, 2'd0};
        frm_tbl[1] = '{8'h07, PAR_EVEN,  1'b1, 1'b0, 1'b1, 2'd1};
        frm_tbl[2] = '{8'hA5, PAR_ODD,   1'b1, 1'b1, 1'b0, 2'd1};
        frm_tbl[3] = '{8'hA5, PAR_MARK,  1'b1, 1'b0, 1'b1, 2'd2};
        frm_tbl[4] = '{8'h3C, PAR_SPACE, 1'b1, 1'b0, 1'b0, 2'd2};
        frm_tbl[5] = '{8'h07, PAR_EVEN,  1'b0, 1'b0, 1'b0, 2'd2};

        bus.PAR_TYP = PAR_EVEN;  bus.PAR_EN = 1'b0;  bus.P_Data = '0;
        bus.Data_Valid = 1'b0;   bus.Frame_Start = 1'b0;
        bus.S_Data = 1'b0;       bus.S_Strobe = 1'b0; bus.Err_Clr = 1'b0;

        tick(); tick();
        check("rst_par_bit", bus.par_bit, 0);
        check("rst_chk_done", bus.chk_done, 0);
        check("rst_par_err", bus.par_err, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        RST = 1'b0;
        tick();

        // Generator vectors
        for (int i = 0; i < 7; i++) begin
            bus.P_Data     = gen_tbl[i].data;
            bus.PAR_TYP    = gen_tbl[i].typ;
            bus.Data_Valid = 1'b1;
            tick();
            bus.Data_Valid = 1'b0;
            check($sformatf("gen_%0d", i), bus.par_bit, gen_tbl[i].exp);
        end
        bus.P_Data  = 8'h00;
        bus.PAR_TYP = PAR_EVEN;
        tick(); tick();
        check("gen_hold", bus.par_bit, 1);

        // Checker frames, issued back to back
        for (int i = 0; i < 6; i++)
            run_frame(frm_tbl[i].data, frm_tbl[i].typ, frm_tbl[i].en, frm_tbl[i].pbit,
                      1'b0, frm_tbl[i].exp_err, frm_tbl[i].exp_cnt);
        tick();

        // Reset in the middle of a frame
        bus.Frame_Start = 1'b1; bus.PAR_TYP = PAR_EVEN; bus.PAR_EN = 1'b1;
        tick();
        bus.Frame_Start = 1'b0;
        strobe(1'b1); strobe(1'b0); strobe(1'b1);
        RST = 1'b1;
        #1;
        check("midrst_par_bit", bus.par_bit, 0);
        check("midrst_chk_done", bus.chk_done, 0);
        check("midrst_par_err", bus.par_err, 0);
        check("midrst_err_cnt", bus.err_cnt, 0);
        tick(); tick();
        RST = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            strobe(1'b1);
            check("idle_strobe_ignored", bus.chk_done, 0);
        end
        run_frame(8'h07, PAR_EVEN, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        tick();
        pulse_clr("clr_alone_1");

        // Abort: second Frame_Start coincides with a strobe
        bus.Frame_Start = 1'b1; bus.PAR_TYP = PAR_EVEN; bus.PAR_EN = 1'b1;
        tick();
        bus.Frame_Start = 1'b0;
        strobe(1'b1); strobe(1'b1); strobe(1'b1); strobe(1'b0);
        check("pre_abort_no_done", bus.chk_done, 0);
        bus.Frame_Start = 1'b1; bus.S_Strobe = 1'b1; bus.S_Data = 1'b1;
        tick();
        bus.Frame_Start = 1'b0; bus.S_Strobe = 1'b0; bus.S_Data = 1'b0;
        check("abort_no_done", bus.chk_done, 0);
        bus.PAR_TYP = PAR_ODD;
        for (int i = 0; i < 8; i++) begin
            strobe(i < 3);
            check("abort_data_no_done", bus.chk_done, 0);
        end
        strobe(1'b1);
        check("abort_done", bus.chk_done, 1);
        check("abort_err", bus.par_err, 0);
        tick();
        check("abort_done_once", bus.chk_done, 0);

        // PAR_EN=0 then a stray strobe in IDLE
        run_frame(8'h5A, PAR_ODD, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        strobe(1'b1);
        check("noparity_idle_strobe", bus.chk_done, 0);
        tick();

        // Saturation and clear behaviour of the 2-bit counter
        run_frame(8'h07, PAR_EVEN, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        run_frame(8'h07, PAR_EVEN, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
        run_frame(8'h07, PAR_EVEN, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
        run_frame(8'h07, PAR_EVEN, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
        tick();
        pulse_clr("clr_alone_2");
        run_frame(8'hA5, PAR_MARK, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        run_frame(8'hA5, PAR_MARK, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1);
        tick();
        check("final_cnt", bus.err_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
